// File: rtl/axil_sig_reader_pkg.sv
// Shared types and constants for the signature reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_sig_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DATA = 3'd2,
      OUT  = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_sig_reader_if.sv
// AXI-Lite master bus plus outgoing signature stream, bundled for the reader.
// Latency: n/a (wires only).
// Backpressure: arready/rvalid from the slave, tready from the stream sink.
interface axil_sig_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] m_axil_araddr;
   logic [2:0]            m_axil_arprot;
   logic                  m_axil_arvalid;
   logic                  m_axil_arready;
   logic [DATA_WIDTH-1:0] m_axil_rdata;
   logic [1:0]            m_axil_rresp;
   logic                  m_axil_rvalid;
   logic                  m_axil_rready;
   logic [ADDR_WIDTH-1:0] m_axil_awaddr;
   logic [2:0]            m_axil_awprot;
   logic                  m_axil_awvalid;
   logic [DATA_WIDTH-1:0] m_axil_wdata;
   logic [STRB_WIDTH-1:0] m_axil_wstrb;
   logic                  m_axil_wvalid;
   logic                  m_axil_bready;
   logic [DATA_WIDTH-1:0] sig_tdata;
   logic                  sig_tvalid;
   logic                  sig_tready;
   logic                  sig_tlast;

   modport master (
      output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
      input  m_axil_arready,
      input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
      output m_axil_rready,
      output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
      output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
      output sig_tdata, sig_tvalid, sig_tlast,
      input  sig_tready
   );

   modport slave (
      input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
      output m_axil_arready,
      output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
      input  m_axil_rready,
      input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
      input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
      input  sig_tdata, sig_tvalid, sig_tlast,
      output sig_tready
   );
endinterface

// File: rtl/axil_sig_reader.sv
// Walks [sig_begin, sig_end) over AXI-Lite reads and streams each word with tlast.
// Latency: 3 cycles per word with zero-wait slave and ready sink; one read outstanding.
// Backpressure: holds the captured word while tready is low; no new read issued meanwhile.
// Optional: SIG_READER_CSUM_EN adds a rotate-xor checksum output sig_csum.
module axil_sig_reader
   import axil_sig_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] sig_begin,
   input  logic [ADDR_WIDTH-1:0] sig_end,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           word_count,
   axil_sig_reader_if.master     bus
`ifdef SIG_READER_CSUM_EN
   ,
   output logic [31:0]           sig_csum
`endif
);

   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_end;
   logic [DATA_WIDTH-1:0] r_data;
   logic [15:0]           r_wcnt;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] w_begin;
   logic [ADDR_WIDTH-1:0] w_end;
   logic                  w_last;
   logic                  w_t_hs;

   assign w_begin = sig_begin & WORD_MASK;
   assign w_end   = sig_end & WORD_MASK;
   // Wrapping regions give begin >= end and are therefore treated as empty.
   assign w_last  = ((r_addr + WORD_STEP) == r_end);
   assign w_t_hs  = (r_state == OUT) && bus.sig_tready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (start) w_next = (w_begin >= w_end) ? FIN : ADDR;
         ADDR: if (bus.m_axil_arready) w_next = DATA;
         DATA: if (bus.m_axil_rvalid)
                  w_next = (bus.m_axil_rresp != RESP_OKAY) ? FIN : OUT;
         OUT:  if (bus.sig_tready) w_next = w_last ? FIN : ADDR;
         FIN:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Address counter, capture register, word counter and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_end  <= '0;
         r_data <= '0;
         r_wcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == IDLE && start) begin
            r_addr <= w_begin;
            r_end  <= w_end;
            r_wcnt <= '0;
            r_err  <= 1'b0;
         end
         if (r_state == DATA && bus.m_axil_rvalid) begin
            if (bus.m_axil_rresp == RESP_OKAY) r_data <= bus.m_axil_rdata;
            else                               r_err  <= 1'b1;
         end
         if (w_t_hs) begin
            r_addr <= r_addr + WORD_STEP;
            if (r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
         end
      end
   end

`ifdef SIG_READER_CSUM_EN
   logic [31:0] r_csum;

   // Rotate-left-by-one then xor each emitted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           r_csum <= '0;
      else if (r_state == IDLE && start) r_csum <= '0;
      else if (w_t_hs)                   r_csum <= {r_csum[30:0], r_csum[31]} ^ r_data;
   end

   assign sig_csum = r_csum;
`endif

   assign bus.m_axil_araddr  = r_addr;
   assign bus.m_axil_arprot  = 3'b000;
   assign bus.m_axil_arvalid = (r_state == ADDR);
   assign bus.m_axil_rready  = (r_state == DATA);
   assign bus.m_axil_awaddr  = '0;
   assign bus.m_axil_awprot  = 3'b000;
   assign bus.m_axil_awvalid = 1'b0;
   assign bus.m_axil_wdata   = '0;
   assign bus.m_axil_wstrb   = '0;
   assign bus.m_axil_wvalid  = 1'b0;
   assign bus.m_axil_bready  = 1'b0;
   assign bus.sig_tdata      = r_data;
   assign bus.sig_tvalid     = (r_state == OUT);
   assign bus.sig_tlast      = (r_state == OUT) && w_last;

   assign busy       = (r_state != IDLE);
   assign done       = (r_state == FIN);
   assign error      = r_err;
   assign word_count = r_wcnt;

endmodule

// File: tb/tb_axil_sig_reader.sv
// Directed bench for axil_sig_reader: bus slave and stream sink driven on the falling edge.
module tb_axil_sig_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] sig_begin;
   logic [31:0] sig_end;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] word_count;
`ifdef SIG_READER_CSUM_EN
   logic [31:0] sig_csum;
`endif
   logic [31:0] exp_csum;

   int checks = 0;
   int errors = 0;

   axil_sig_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   axil_sig_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sig_begin  (sig_begin),
      .sig_end    (sig_end),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count),
      .bus        (bus)
`ifdef SIG_READER_CSUM_EN
      ,
      .sig_csum   (sig_csum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a start request for one cycle; returns at the falling edge after it was sampled.
   task automatic do_start(input logic [31:0] b, input logic [31:0] e);
      @(negedge clk);
      start = 1'b1; sig_begin = b; sig_end = e;
      exp_csum = 32'h0;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Serve one read and consume the resulting stream word.
   task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int hold, input logic exp_last);
      int n = 0;
      while (bus.m_axil_arvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("arvalid", {31'b0, bus.m_axil_arvalid}, 32'h1);
      chk("araddr", bus.m_axil_araddr, addr);
      @(negedge clk);
      chk("rready", {31'b0, bus.m_axil_rready}, 32'h1);
      bus.m_axil_rvalid = 1'b1; bus.m_axil_rdata = data; bus.m_axil_rresp = resp;
      @(negedge clk);
      bus.m_axil_rvalid = 1'b0; bus.m_axil_rresp = 2'b00; bus.m_axil_rdata = 32'h0;
      if (resp != 2'b00) return;
      chk("tvalid", {31'b0, bus.sig_tvalid}, 32'h1);
      chk("tdata", bus.sig_tdata, data);
      chk("tlast", {31'b0, bus.sig_tlast}, {31'b0, exp_last});
      for (int h = 0; h < hold; h++) begin
         bus.sig_tready = 1'b0;
         @(negedge clk);
         chk("hold_tvalid", {31'b0, bus.sig_tvalid}, 32'h1);
         chk("hold_tdata", bus.sig_tdata, data);
         chk("hold_tlast", {31'b0, bus.sig_tlast}, {31'b0, exp_last});
         chk("hold_no_ar", {31'b0, bus.m_axil_arvalid}, 32'h0);
      end
      bus.sig_tready = 1'b1;
      exp_csum = {exp_csum[30:0], exp_csum[31]} ^ data;
      @(negedge clk);
   endtask

   // Check the FIN cycle, then the return to idle.
   task automatic end_check(input logic [15:0] wc, input logic err);
      chk("done", {31'b0, done}, 32'h1);
      chk("word_count", {16'b0, word_count}, {16'b0, wc});
      chk("error", {31'b0, error}, {31'b0, err});
      chk("busy_fin", {31'b0, busy}, 32'h1);
      chk("tvalid_fin", {31'b0, bus.sig_tvalid}, 32'h0);
`ifdef SIG_READER_CSUM_EN
      chk("csum", sig_csum, exp_csum);
`endif
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 32'h0);
      chk("busy_idle", {31'b0, busy}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sig_begin = 32'h0; sig_end = 32'h0;
      exp_csum = 32'h0;
      bus.m_axil_arready = 1'b1; bus.m_axil_rvalid = 1'b0;
      bus.m_axil_rdata = 32'h0; bus.m_axil_rresp = 2'b00;
      bus.sig_tready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state and write-channel tie-offs.
      chk("rst_arvalid", {31'b0, bus.m_axil_arvalid}, 32'h0);
      chk("rst_rready", {31'b0, bus.m_axil_rready}, 32'h0);
      chk("rst_tvalid", {31'b0, bus.sig_tvalid}, 32'h0);
      chk("rst_tlast", {31'b0, bus.sig_tlast}, 32'h0);
      chk("rst_tdata", bus.sig_tdata, 32'h0);
      chk("rst_araddr", bus.m_axil_araddr, 32'h0);
      chk("rst_status", {28'b0, busy, done, error, 1'b0}, 32'h0);
      chk("rst_wcnt", {16'b0, word_count}, 32'h0);
      chk("tie_aw", {bus.m_axil_awaddr[30:0], bus.m_axil_awvalid}, 32'h0);
      chk("tie_w", {bus.m_axil_wdata[26:0], bus.m_axil_wstrb, bus.m_axil_wvalid}, 32'h0);
      chk("tie_misc", {26'b0, bus.m_axil_awprot, bus.m_axil_arprot}, {26'b0, 6'b0} | {29'b0, bus.m_axil_bready, 2'b0});
      rst = 1'b0;

      // Four-word region, ready sink.
      do_start(32'h2000, 32'h2010);
      chk("busy_start", {31'b0, busy}, 32'h1);
      serve(32'h2000, 32'h11111111, 2'b00, 0, 1'b0);
      serve(32'h2004, 32'h22222222, 2'b00, 0, 1'b0);
      serve(32'h2008, 32'h33333333, 2'b00, 0, 1'b0);
      serve(32'h200C, 32'h44444444, 2'b00, 0, 1'b1);
      end_check(16'd4, 1'b0);

      // Empty region: no read, done in the following cycle.
      do_start(32'h3000, 32'h3000);
      chk("empty_no_ar", {31'b0, bus.m_axil_arvalid}, 32'h0);
      end_check(16'd0, 1'b0);

      // Same region, sink stalls on the second word.
      do_start(32'h2000, 32'h2010);
      serve(32'h2000, 32'h11111111, 2'b00, 0, 1'b0);
      serve(32'h2004, 32'h22222222, 2'b00, 5, 1'b0);
      serve(32'h2008, 32'h33333333, 2'b00, 0, 1'b0);
      serve(32'h200C, 32'h44444444, 2'b00, 0, 1'b1);
      end_check(16'd4, 1'b0);

      // Slave error on the second read.
      do_start(32'h2000, 32'h2010);
      serve(32'h2000, 32'h11111111, 2'b00, 0, 1'b0);
      serve(32'h2004, 32'h22222222, 2'b10, 0, 1'b0);
      end_check(16'd1, 1'b1);
      chk("err_sticky", {31'b0, error}, 32'h1);
      do_start(32'h2008, 32'h200C);
      chk("err_cleared", {31'b0, error}, 32'h0);
      serve(32'h2008, 32'h33333333, 2'b00, 0, 1'b1);
      end_check(16'd1, 1'b0);

      // Reset while waiting for read data.
      do_start(32'h2000, 32'h2010);
      @(negedge clk);
      chk("pre_rst_rready", {31'b0, bus.m_axil_rready}, 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_arvalid", {31'b0, bus.m_axil_arvalid}, 32'h0);
      chk("mid_rst_rready", {31'b0, bus.m_axil_rready}, 32'h0);
      chk("mid_rst_tvalid", {31'b0, bus.sig_tvalid}, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Unaligned bounds are truncated to word addresses.
      do_start(32'h2003, 32'h2009);
      serve(32'h2000, 32'hA5A5_0001, 2'b00, 0, 1'b0);
      serve(32'h2004, 32'h5A5A_0002, 2'b00, 0, 1'b1);
      end_check(16'd2, 1'b0);

      // Region wrapping past the top of the address space is empty.
      do_start(32'hFFFF_FFF8, 32'h0000_0008);
      chk("wrap_no_ar", {31'b0, bus.m_axil_arvalid}, 32'h0);
      end_check(16'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
